// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the opcode constants, the FSM state encoding and the default widths
// used by the interface, the round-robin sub-module and the top.
package alu_pkg;

  localparam int W_DEF     = 8;
  localparam int OPW_DEF   = 3;
  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] OP_RCA  = 3'd0;
  localparam logic [2:0] OP_CLA  = 3'd1;
  localparam logic [2:0] OP_CSA  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_DEC  = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Bus bundle for alu_arbiter_ctrl: two request channels, the ALU port pair,
// the response channel and busy.
//   modport slave  : the arbiter side (accepts requests, drives the ALU).
//   modport master : the environment (engines, external ALU, consumer).
// Optional macro ALU_ARB_STATS_EN adds grant_cnt0/grant_cnt1/stall_cnt.
interface alu_arbiter_ctrl_if import alu_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic           req0_valid, req0_ready;
  logic [W-1:0]   req0_A, req0_B;
  logic [OPW-1:0] req0_op;
  logic           req1_valid, req1_ready;
  logic [W-1:0]   req1_A, req1_B;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   alu_A, alu_B, alu_Y;
  logic [OPW-1:0] alu_op;
  logic           alu_Cout;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_Y;
  logic           rsp_Cout, rsp_id;
  logic           busy;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_op,
    input  req1_valid, req1_A, req1_B, req1_op,
    input  alu_Y, alu_Cout, rsp_ready,
    output req0_ready, req1_ready,
    output alu_A, alu_B, alu_op,
    output rsp_valid, rsp_Y, rsp_Cout, rsp_id, busy
`ifdef ALU_ARB_STATS_EN
    , output grant_cnt0, grant_cnt1, stall_cnt
`endif
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_op,
    output req1_valid, req1_A, req1_B, req1_op,
    output alu_Y, alu_Cout, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_A, alu_B, alu_op,
    input  rsp_valid, rsp_Y, rsp_Cout, rsp_id, busy
`ifdef ALU_ARB_STATS_EN
    , input grant_cnt0, grant_cnt1, stall_cnt
`endif
  );
endinterface

// File: rtl/alu_arbiter_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   req[1:0] : requests (already qualified by the caller)
//   upd      : a grant was taken this cycle; remember its winner
//   gnt[1:0] : one-hot grant (combinational)
//   gnt_id   : index of the granted requester
// last_grant resets to 1 so requester 0 wins the first contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
    gnt_id = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_grant <= 1'b1;
    else if (upd) last_grant <= gnt_id;
  end
endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one external ALU between two requesters.
// Ports: clk, rst_n (async, active low), bus (alu_arbiter_ctrl_if.slave):
//   req0_*/req1_* valid/ready operand channels, alu_* to/from the ALU,
//   rsp_* tagged response channel, busy.
// Flow: IDLE grants and latches operands -> EXEC drives the ALU and
// registers Y/Cout -> RESP holds the result until rsp_ready.
// Optional macro ALU_ARB_STATS_EN adds saturating grant/stall counters.
module alu_arbiter_ctrl import alu_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_ctrl_if.slave bus
);
  typedef struct packed {
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [OPW-1:0] op;
  } opnd_t;

  state_t         state;
  opnd_t          opnd;
  opnd_t [1:0]    req_in;
  logic [1:0]     req_vld, gnt;
  logic           gnt_id, idle, hs;
  logic [W-1:0]   rsp_y_q;
  logic           rsp_c_q, rsp_id_q, rsp_vld_q;

  assign req_in[0] = {bus.req0_A, bus.req0_B, bus.req0_op};
  assign req_in[1] = {bus.req1_A, bus.req1_B, bus.req1_op};
  assign idle      = (state == IDLE);
  // Arbitration only happens in IDLE; masking here keeps ready low elsewhere.
  assign req_vld   = {bus.req1_valid, bus.req0_valid} & {2{idle}};
  assign hs        = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vld),
    .upd    (hs),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // rst_n gating keeps ready low while reset is held even if valid is up.
  assign bus.req0_ready = gnt[0] & rst_n;
  assign bus.req1_ready = gnt[1] & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opnd      <= '0;
      rsp_y_q   <= '0;
      rsp_c_q   <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          opnd     <= req_in[gnt_id];
          rsp_id_q <= gnt_id;
          state    <= EXEC;
        end
        EXEC: begin
          rsp_y_q   <= bus.alu_Y;
          rsp_c_q   <= bus.alu_Cout;
          rsp_vld_q <= 1'b1;
          state     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_vld_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_A     = opnd.A;
  assign bus.alu_B     = opnd.B;
  assign bus.alu_op    = opnd.op;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_Y     = rsp_y_q;
  assign bus.rsp_Cout  = rsp_c_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = !idle;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] gc0, gc1, sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc0 <= '0;
      gc1 <= '0;
      sc  <= '0;
    end else begin
      if (gnt[0] && gc0 != '1) gc0 <= gc0 + 1'b1;
      if (gnt[1] && gc1 != '1) gc1 <= gc1 + 1'b1;
      if (state == RESP && !bus.rsp_ready && sc != '1) sc <= sc + 1'b1;
    end
  end

  assign bus.grant_cnt0 = gc0;
  assign bus.grant_cnt1 = gc1;
  assign bus.stall_cnt  = sc;
`endif
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: reset values, a vector table of
// single-requester operations, hand-written sequences for alternation,
// response back-pressure and reset abort, plus randomized traffic checked
// against a transaction-level model. Also provides the external ALU.
module tb_alu_arbiter_ctrl;
  typedef struct packed {
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
  } opnd_t;

  typedef struct packed {
    logic [1:0] mask;
    opnd_t      r;
    logic [7:0] y;
    logic       c;
  } vec_t;

  logic clk, rst_n;
  int   n_chk, n_fail;
  int   m_last;   // model: id of the most recent grant

  alu_arbiter_ctrl_if #(.W(8), .OPW(3), .CNT_W(16)) bus ();

  alu_arbiter_ctrl #(.W(8), .OPW(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: {Cout, Y} as a 9-bit result.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: return {1'b0, a} + {1'b0, b};
      3'd3, 3'd6:       return {1'b0, a} - {1'b0, b};
      3'd4:             return {1'b0, a} + 9'd1;
      3'd5:             return {1'b0, a} - 9'd1;
      default:          return {1'b0, a};
    endcase
  endfunction

  assign {bus.alu_Cout, bus.alu_Y} = alu_ref(bus.alu_A, bus.alu_B, bus.alu_op);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mask, input opnd_t r0, input opnd_t r1);
    bus.req0_valid = mask[0];
    bus.req0_A = r0.A; bus.req0_B = r0.B; bus.req0_op = r0.op;
    bus.req1_valid = mask[1];
    bus.req1_A = r1.A; bus.req1_B = r1.B; bus.req1_op = r1.op;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(2'b00, '0, '0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1;
  endtask

  // Wait for a response (bounded), compare it, then accept it.
  task automatic finish_rsp(input string name, input int id, input logic [8:0] exp);
    int lat;
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    check({name, "_valid"}, bus.rsp_valid, 1);
    check({name, "_id"}, bus.rsp_id, id);
    check({name, "_y"}, {bus.rsp_Cout, bus.rsp_Y}, exp);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // One complete transaction; returns the granted id and observed result.
  task automatic run_txn(input logic [1:0] mask, input opnd_t r0, input opnd_t r1,
                         input int stall, output int gid, output logic [8:0] res);
    bit    got;
    int    lat, exp_id;
    opnd_t g;
    @(negedge clk);
    drive(mask, r0, r1);
    got = 0; gid = -1; res = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1;
        check("one_ready", {bus.req0_ready, bus.req1_ready}, (bus.req1_ready ? 2'b01 : 2'b10));
        gid = bus.req1_ready ? 1 : 0;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      drive(2'b00, '0, '0);
      return;
    end
    exp_id = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : 1 - m_last;
    check("grant_id", gid, exp_id);
    m_last = gid;
    g = gid ? r1 : r0;
    // Scramble the request side: the in-flight operation must not notice.
    drive(2'b00, opnd_t'($urandom), opnd_t'($urandom));
    #1;
    check("exec_busy", bus.busy, 1);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    check("exec_alu", {bus.alu_A, bus.alu_B, bus.alu_op}, g);
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", lat, 2);
    check("rsp_id", bus.rsp_id, gid);
    res = {bus.rsp_Cout, bus.rsp_Y};
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_Cout, bus.rsp_Y},
            {1'b1, gid[0], res});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_cleared", bus.rsp_valid, 0);
  endtask

  vec_t       vt[8];
  int         gid;
  logic [8:0] res, exp;
  opnd_t      ra, rb;
  bit         got;

  initial begin
    n_chk = 0; n_fail = 0; m_last = 1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(2'b11, '{A: 8'd3, B: 8'd4, op: 3'd0}, '{A: 8'd5, B: 8'd6, op: 3'd1});
    #2 rst_n = 1'b0;
    #1;
    // Reset values, with both valids high to prove ready stays low.
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp", {bus.rsp_Y, bus.rsp_Cout, bus.rsp_id}, 0);
    check("rst_alu", {bus.alu_A, bus.alu_B, bus.alu_op}, 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    apply_reset();

    // Single-requester vector table with hand-computed results.
    vt[0] = '{2'b01, '{8'd200, 8'd100, 3'd0}, 8'd44,   1'b1};
    vt[1] = '{2'b10, '{8'd5,   8'd10,  3'd3}, 8'hFB,   1'b1};
    vt[2] = '{2'b01, '{8'd7,   8'd0,   3'd7}, 8'd7,    1'b0};
    vt[3] = '{2'b10, '{8'd255, 8'd1,   3'd4}, 8'd0,    1'b1};
    vt[4] = '{2'b01, '{8'd0,   8'd1,   3'd5}, 8'hFF,   1'b1};
    vt[5] = '{2'b10, '{8'd100, 8'd27,  3'd1}, 8'd127,  1'b0};
    vt[6] = '{2'b01, '{8'd128, 8'd128, 3'd2}, 8'd0,    1'b1};
    vt[7] = '{2'b10, '{8'd9,   8'd3,   3'd6}, 8'd6,    1'b0};
    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].mask, vt[i].r, vt[i].r, i % 3, gid, res);
      check($sformatf("vec%0d_result", i), res, {vt[i].c, vt[i].y});
    end

    // Both valid continuously from reset: grants alternate 0,1,0,1.
    apply_reset();
    ra = '{8'd10, 8'd20, 3'd0};
    rb = '{8'd50, 8'd60, 3'd3};
    drive(2'b11, ra, rb);
    for (int t = 0; t < 4; t++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        #1;
        if (bus.req0_ready || bus.req1_ready) begin got = 1; gid = bus.req1_ready ? 1 : 0; end
        @(negedge clk);
      end
      if (!got) check("alt_timeout", 0, 1);
      check("alt_grant", gid, t % 2);
      exp = gid ? alu_ref(rb.A, rb.B, rb.op) : alu_ref(ra.A, ra.B, ra.op);
      finish_rsp("alt", t % 2, exp);
    end
    drive(2'b00, '0, '0);
    m_last = 1;

    // Back-pressure: rsp_ready low 5 cycles while req1 waits.
    @(negedge clk);
    drive(2'b01, '{8'd9, 8'd3, 3'd6}, '0);
    #1 check("bp_grant0", bus.req0_ready, 1);
    @(negedge clk);
    drive(2'b10, '0, '{8'd1, 8'd1, 3'd0});
    #1 check("bp_exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_Cout, bus.rsp_Y}, {1'b1, 1'b0, 9'd6});
      check("bp_ready_low", {bus.req0_ready, bus.req1_ready}, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 check("bp_same_cycle", bus.req1_ready, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 check("bp_next_grant", bus.req1_ready, 1);
    @(negedge clk);
    drive(2'b00, '0, '0);
    finish_rsp("bp2", 1, 9'd2);
    m_last = 1;

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    drive(2'b10, '0, '{8'd1, 8'd2, 3'd0});
    #1 check("ab_grant", bus.req1_ready, 1);
    @(negedge clk);
    drive(2'b00, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("ab_busy", bus.busy, 0);
    check("ab_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_Cout, bus.rsp_Y}, 0);
    check("ab_alu", {bus.alu_A, bus.alu_B, bus.alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ab_no_stale", {bus.rsp_valid, bus.busy}, 0);
    end
    run_txn(2'b11, '{8'd4, 8'd4, 3'd0}, '{8'd8, 8'd8, 3'd0}, 0, gid, res);
    check("ab_first_req0", gid, 0);
    check("ab_result", res, 9'd8);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      ra = opnd_t'($urandom);
      rb = opnd_t'($urandom);
      run_txn(2'($urandom_range(1, 3)), ra, rb, $urandom_range(0, 2), gid, res);
      exp = (gid == 1) ? alu_ref(rb.A, rb.B, rb.op) : alu_ref(ra.A, ra.B, ra.op);
      check("rand_result", res, exp);
    end

`ifdef ALU_ARB_STATS_EN
    apply_reset();
    check("st_reset", {bus.grant_cnt0, bus.grant_cnt1, bus.stall_cnt}, 0);
    run_txn(2'b01, '{8'd1, 8'd1, 3'd0}, '0, 2, gid, res);
    run_txn(2'b10, '0, '{8'd2, 8'd1, 3'd3}, 1, gid, res);
    run_txn(2'b01, '{8'd3, 8'd1, 3'd4}, '0, 1, gid, res);
    run_txn(2'b10, '0, '{8'd4, 8'd1, 3'd5}, 0, gid, res);
    run_txn(2'b01, '{8'd5, 8'd1, 3'd7}, '0, 0, gid, res);
    check("st_grant0", bus.grant_cnt0, 3);
    check("st_grant1", bus.grant_cnt1, 2);
    check("st_stall", bus.stall_cnt, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
